axil_reg_arbiter: RTL

- Shares one AXI4-Lite slave register block, the 4 x 32-bit signal_ip register file, among NUM_REQ local requesters.
- Each requester uses a simple valid/ready command port and receives a one-cycle response pulse.
- Round-robin arbitration; exactly one AXI4-Lite transaction outstanding at a time.
- Sits between the control logic (sequencers, CPU bridge) and the slave's S00_AXI port.

---
 rtl/axil_reg_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axil_reg_arbiter.sv
// Round-robin arbiter that lets NUM_REQ local requesters share one AXI4-Lite register slave.
// Define AXIL_REG_ARBITER_TIMEOUT_EN to add the watchdog and its sticky timeout_err output.

module axil_reg_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = 4,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic [1:0]                rsp_resp,
   output logic                      busy,
   output logic [ADDR_W-1:0]         m_axi_awaddr,
   output logic [2:0]                m_axi_awprot,
   output logic                      m_axi_awvalid,
   input  logic                      m_axi_awready,
   output logic [DATA_W-1:0]         m_axi_wdata,
   output logic [DATA_W/8-1:0]       m_axi_wstrb,
   output logic                      m_axi_wvalid,
   input  logic                      m_axi_wready,
   input  logic [1:0]                m_axi_bresp,
   input  logic                      m_axi_bvalid,
   output logic                      m_axi_bready,
   output logic [ADDR_W-1:0]         m_axi_araddr,
   output logic [2:0]                m_axi_arprot,
   output logic                      m_axi_arvalid,
   input  logic                      m_axi_arready,
   input  logic [DATA_W-1:0]         m_axi_rdata,
   input  logic [1:0]                m_axi_rresp,
   input  logic                      m_axi_rvalid,
   output logic                      m_axi_rready
`ifdef AXIL_REG_ARBITER_TIMEOUT_EN
   ,
   output logic                      timeout_err
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W:0] NUM_REQ_L = (IDX_W+1)'(NUM_REQ);

   typedef enum logic [2:0] {IDLE, WR_AD, WR_B, RD_A, RD_R, RSP} state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    last_q, owner_q, win, cand;
   logic [IDX_W:0]      sum_c;
   logic                win_vld;
   logic [ADDR_W-1:0]   addr_q, sel_addr;
   logic [DATA_W-1:0]   wdata_q, sel_wdata;
   logic                aw_done, w_done, aw_hs, w_hs, tmo_hit;

   assign aw_hs        = m_axi_awvalid && m_axi_awready;
   assign w_hs         = m_axi_wvalid && m_axi_wready;
   assign busy         = (state != IDLE);
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;
   assign m_axi_wstrb  = '1;

   // Scan from last+1 upward; descending loop lets the nearest candidate win.
   always_comb begin
      win       = last_q;
      win_vld   = 1'b0;
      sum_c     = '0;
      cand      = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         sum_c = {1'b0, last_q} + (IDX_W+1)'(k);
         if (sum_c >= NUM_REQ_L) sum_c = sum_c - NUM_REQ_L;
         cand = sum_c[IDX_W-1:0];
         if (req_valid[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == IDX_W'(i)) begin
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      req_ready     = '0;
      rsp_valid     = '0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld && !reset) begin
               req_ready[win] = 1'b1;
               state_nxt      = req_we[win] ? WR_AD : RD_A;
            end
         end
         WR_AD: begin
            m_axi_awvalid = !aw_done;
            m_axi_wvalid  = !w_done;
            if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nxt = WR_B;
         end
         WR_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_nxt = RSP;
         end
         RD_A: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_nxt = RD_R;
         end
         RD_R: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) state_nxt = RSP;
         end
         RSP: begin
            rsp_valid[owner_q] = 1'b1;
            state_nxt          = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (tmo_hit) state_nxt = RSP;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         last_q    <= IDX_W'(NUM_REQ-1);
         owner_q   <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rsp_rdata <= '0;
         rsp_resp  <= 2'b00;
      end else begin
         state <= state_nxt;
         if (state == IDLE && win_vld) begin
            last_q  <= win;
            owner_q <= win;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
         if (state == WR_B && m_axi_bvalid) begin
            rsp_rdata <= '0;
            rsp_resp  <= m_axi_bresp;
         end
         if (state == RD_R && m_axi_rvalid) begin
            rsp_rdata <= m_axi_rdata;
            rsp_resp  <= m_axi_rresp;
         end
         if (tmo_hit) begin
            rsp_rdata <= '0;
            rsp_resp  <= 2'b10;
         end
      end
   end

`ifdef AXIL_REG_ARBITER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             in_wait;

   // Counter restarts on every state change, so each wait state gets its own budget.
   assign in_wait = (state == WR_AD) || (state == WR_B) || (state == RD_A) || (state == RD_R);
   assign tmo_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q       <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state_nxt != state) cnt_q <= '0;
         else if (in_wait)       cnt_q <= cnt_q + 1'b1;
         if (tmo_hit) timeout_err <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

endmodule
